// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction fetch sequencer with 1-cycle ROM latency, skid buffer and redirect
// Optional feature: define FETCH_JMP_DECODE_EN to redirect fetch on issued JMP words.
module fetch_sequencer #(
    parameter logic [5:0]  P_OPCODE_JMP = 6'd0,
    parameter logic [15:0] P_NOP_WORD   = 16'h0000
) (
    input  logic        Clock,
    input  logic        Reset,
    output logic [9:0]  Ip,
    input  logic [15:0] Instr,
    input  logic        Stall,
    input  logic        Redirect,
    input  logic [9:0]  Target,
    output logic [15:0] IssueInstr,
    output logic        IssueValid,
    output logic [9:0]  IssuePc
);

`ifdef FETCH_JMP_DECODE_EN
    localparam logic JMP_DECODE = 1'b1;
`else
    localparam logic JMP_DECODE = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_FILL,
        S_RUN,
        S_HOLD,
        S_REDIR
    } state_t;

    state_t      state_q, state_d;
    logic [9:0]  ip_q, ip_d;
    logic        if_valid_q, if_valid_d;
    logic [9:0]  if_addr_q, if_addr_d;
    logic        sk_valid_q, sk_valid_d;
    logic [15:0] sk_instr_q, sk_instr_d;
    logic [9:0]  sk_pc_q, sk_pc_d;
    logic        iss_valid_q, iss_valid_d;
    logic [15:0] iss_instr_q, iss_instr_d;
    logic [9:0]  iss_pc_q, iss_pc_d;

    logic        sel_valid;
    logic [15:0] sel_instr;
    logic [9:0]  sel_pc;
    logic        ip_reread;
    logic        jmp_hit;
    logic        jmp_taken;

    always_comb begin
        state_d     = state_q;
        ip_d        = ip_q;
        if_valid_d  = if_valid_q;
        if_addr_d   = if_addr_q;
        sk_valid_d  = sk_valid_q;
        sk_instr_d  = sk_instr_q;
        sk_pc_d     = sk_pc_q;
        iss_valid_d = iss_valid_q;
        iss_instr_d = iss_instr_q;
        iss_pc_d    = iss_pc_q;

        // Ip was held last cycle, so the in-flight word is ROM[Ip] and keeps arriving on Instr.
        ip_reread = if_valid_q && (if_addr_q == ip_q);

        if (sk_valid_q) begin
            sel_valid = 1'b1;
            sel_instr = sk_instr_q;
            sel_pc    = sk_pc_q;
        end else begin
            sel_valid = if_valid_q;
            sel_instr = Instr;
            sel_pc    = if_addr_q;
        end

        jmp_hit   = sel_valid && (sel_instr[15:10] == P_OPCODE_JMP);
        jmp_taken = jmp_hit && JMP_DECODE;

        case (state_q)
            S_FILL:  state_d = S_RUN;
            S_REDIR: state_d = S_RUN;
            S_RUN:   if (Stall && if_valid_q) state_d = S_HOLD;
            S_HOLD:  if (!Stall) state_d = S_RUN;
            default: state_d = S_FILL;
        endcase

        if (Redirect) begin
            state_d     = S_REDIR;
            ip_d        = Target;
            if_valid_d  = 1'b0;
            sk_valid_d  = 1'b0;
            iss_valid_d = 1'b0;
            iss_instr_d = P_NOP_WORD;
        end else if (Stall) begin
            // Only a word whose address Ip has already moved past would be lost.
            if (if_valid_q && !sk_valid_q && !ip_reread) begin
                sk_valid_d = 1'b1;
                sk_instr_d = Instr;
                sk_pc_d    = if_addr_q;
            end
            if_valid_d = 1'b1;
            if_addr_d  = ip_q;
        end else begin
            iss_valid_d = sel_valid;
            iss_instr_d = sel_valid ? sel_instr : P_NOP_WORD;
            iss_pc_d    = sel_pc;
            sk_valid_d  = 1'b0;
            ip_d        = ip_q + 10'd1;
            if_addr_d   = ip_q;
            // Issuing ROM[Ip] directly means Ip itself must not be fetched a second time.
            if_valid_d  = sk_valid_q || !ip_reread;
            if (jmp_taken) begin
                ip_d       = sel_instr[9:0];
                if_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= S_FILL;
            ip_q        <= 10'h000;
            if_valid_q  <= 1'b0;
            if_addr_q   <= 10'h000;
            sk_valid_q  <= 1'b0;
            sk_instr_q  <= P_NOP_WORD;
            sk_pc_q     <= 10'h000;
            iss_valid_q <= 1'b0;
            iss_instr_q <= P_NOP_WORD;
            iss_pc_q    <= 10'h000;
        end else begin
            state_q     <= state_d;
            ip_q        <= ip_d;
            if_valid_q  <= if_valid_d;
            if_addr_q   <= if_addr_d;
            sk_valid_q  <= sk_valid_d;
            sk_instr_q  <= sk_instr_d;
            sk_pc_q     <= sk_pc_d;
            iss_valid_q <= iss_valid_d;
            iss_instr_q <= iss_instr_d;
            iss_pc_q    <= iss_pc_d;
        end
    end

    assign Ip         = ip_q;
    assign IssueInstr = iss_instr_q;
    assign IssueValid = iss_valid_q;
    assign IssuePc    = iss_pc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed self-checking bench for fetch_sequencer
module tb_fetch_sequencer;

    localparam logic [5:0]  JMP_OP = 6'h3E;
    localparam logic [15:0] NOP    = 16'hC0DE;

    logic        Clock;
    logic        Reset;
    logic [9:0]  Ip;
    logic [15:0] Instr;
    logic        Stall;
    logic        Redirect;
    logic [9:0]  Target;
    logic [15:0] IssueInstr;
    logic        IssueValid;
    logic [9:0]  IssuePc;

    int n_checks = 0;
    int n_errors = 0;

    fetch_sequencer #(
        .P_OPCODE_JMP(JMP_OP),
        .P_NOP_WORD  (NOP)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Ip        (Ip),
        .Instr     (Instr),
        .Stall     (Stall),
        .Redirect  (Redirect),
        .Target    (Target),
        .IssueInstr(IssueInstr),
        .IssueValid(IssueValid),
        .IssuePc   (IssuePc)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic logic [15:0] rom_word(input logic [9:0] a);
        if (a == 10'd17) return {JMP_OP, 10'd3};
        return 16'h1000 + {6'd0, a};
    endfunction

    always @(posedge Clock) Instr <= rom_word(Ip);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic expect_issue(input string tag, input logic [9:0] pc, input logic [15:0] word);
        check_eq({tag, ".valid"}, {31'd0, IssueValid}, 32'd1);
        check_eq({tag, ".pc"}, {22'd0, IssuePc}, {22'd0, pc});
        check_eq({tag, ".instr"}, {16'd0, IssueInstr}, {16'd0, word});
    endtask

    task automatic expect_bubble(input string tag);
        check_eq({tag, ".valid"}, {31'd0, IssueValid}, 32'd0);
        check_eq({tag, ".nop"}, {16'd0, IssueInstr}, {16'd0, NOP});
    endtask

    task automatic redirect_to(input logic [9:0] t, input logic with_stall);
        Redirect = 1'b1;
        Target   = t;
        Stall    = with_stall;
        tick();
        Redirect = 1'b0;
        Stall    = 1'b0;
    endtask

    initial begin
        Reset    = 1'b1;
        Stall    = 1'b0;
        Redirect = 1'b0;
        Target   = 10'h000;
        repeat (3) tick();
        check_eq("rst.ip", {22'd0, Ip}, 32'd0);
        check_eq("rst.pc", {22'd0, IssuePc}, 32'd0);
        expect_bubble("rst");

        Reset = 1'b0;
        tick();
        expect_bubble("fill");
        for (int i = 0; i < 6; i++) begin
            tick();
            expect_issue($sformatf("seq%0d", i), 10'(i), 16'h1000 + 16'(i));
        end
        check_eq("seq.ip", {22'd0, Ip}, 32'd7);

        Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_issue($sformatf("stall%0d", i), 10'd5, 16'h1005);
            check_eq($sformatf("stall%0d.ip", i), {22'd0, Ip}, 32'd7);
        end
        Stall = 1'b0;
        for (int i = 6; i < 10; i++) begin
            tick();
            expect_issue($sformatf("resume%0d", i), 10'(i), 16'h1000 + 16'(i));
        end

        redirect_to(10'h100, 1'b0);
        expect_bubble("redir0");
        check_eq("redir.ip", {22'd0, Ip}, 32'h100);
        tick();
        expect_bubble("redir1");
        tick();
        expect_issue("redir.tgt", 10'h100, 16'h1100);
        tick();
        expect_issue("redir.next", 10'h101, 16'h1101);

        redirect_to(10'd15, 1'b0);
        tick();
        tick();
        expect_issue("jmp15", 10'd15, 16'h100F);
        tick();
        expect_issue("jmp16", 10'd16, 16'h1010);
        tick();
        expect_issue("jmp17", 10'd17, {JMP_OP, 10'd3});
`ifdef FETCH_JMP_DECODE_EN
        tick();
        expect_bubble("jmp.bubble");
        tick();
        expect_issue("jmp.tgt", 10'd3, 16'h1003);
`else
        tick();
        expect_issue("jmp18", 10'd18, 16'h1012);
        tick();
        expect_issue("jmp19", 10'd19, 16'h1013);
`endif

        redirect_to(10'h3FE, 1'b0);
        tick();
        tick();
        expect_issue("wrap3fe", 10'h3FE, 16'h13FE);
        tick();
        expect_issue("wrap3ff", 10'h3FF, 16'h13FF);
        tick();
        expect_issue("wrap000", 10'h000, 16'h1000);

        Stall = 1'b1;
        tick();
        tick();
        expect_issue("skid.hold", 10'h000, 16'h1000);
        redirect_to(10'h020, 1'b1);
        expect_bubble("rs0");
        tick();
        expect_bubble("rs1");
        tick();
        expect_issue("rs.tgt", 10'h020, 16'h1020);
        tick();
        expect_issue("rs.next", 10'h021, 16'h1021);

        Stall = 1'b1;
        tick();
        tick();
        Reset = 1'b1;
        tick();
        Stall = 1'b0;
        Reset = 1'b0;
        check_eq("rst2.ip", {22'd0, Ip}, 32'd0);
        check_eq("rst2.pc", {22'd0, IssuePc}, 32'd0);
        expect_bubble("rst2");
        tick();
        expect_bubble("rst2.fill");
        tick();
        expect_issue("rst2.first", 10'd0, 16'h1000);
        tick();
        expect_issue("rst2.second", 10'd1, 16'h1001);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
